// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the program/data memory port arbiter.
package mem_arb_pkg;
  localparam int MEM_AW = 4;
  localparam int MEM_DW = 4;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with an override (lock owner); combinational pick, zero latency.
// Pointer advances to the winner on every grant; no grant when neither requester is valid.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       ovr_en,
  input  logic       ovr_id,
  output logic       win_vld,
  output logic       win_id
);

  logic last_id;

  always_comb begin
    win_vld = |valid;
    win_id  = REQ_CPU;
    if (ovr_en)          win_id = ovr_id;
    else if (&valid)     win_id = ~last_id;
    else if (valid[1])   win_id = REQ_HOST;
  end

  // Reset to HOST so the CPU takes the first contested grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_id <= REQ_HOST;
    else if (win_vld) last_id <= win_id;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between CPU and host with round-robin plus bounded lock.
// Grant is combinational (same-cycle ready); read data returns one cycle later to the issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = MEM_AW,
  parameter int DW       = MEM_DW,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic          req0_lock,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic          req1_lock,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          grant_id,
  output logic          lock_active
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  lock_state_e   state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    vld, lck;
  logic          ovr_en, win_vld, win_id;
  logic          rd_pend_q, rd_owner_q, gid_q;

  assign vld = {req1_valid, req0_valid};
  assign lck = {req1_lock, req0_lock};

  // Lock only overrides while the owner is asking and the budget is not exhausted.
  assign ovr_en = (state_q == LOCKED) && vld[owner_q] && (cnt_q < CW'(LOCK_MAX));

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .valid   (vld),
    .ovr_en  (ovr_en),
    .ovr_id  (owner_q),
    .win_vld (win_vld),
    .win_id  (win_id)
  );

  assign req0_ready = win_vld && (win_id == REQ_CPU);
  assign req1_ready = win_vld && (win_id == REQ_HOST);

  always_comb begin
    mem_en    = win_vld;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (win_vld) begin
      if (win_id == REQ_HOST) begin
        mem_we    = req1_we;
        mem_addr  = req1_addr;
        mem_wdata = req1_wdata;
      end else begin
        mem_we    = req0_we;
        mem_addr  = req0_addr;
        mem_wdata = req0_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (win_vld && lck[win_id]) begin
          state_d = LOCKED;
          owner_d = win_id;
          cnt_d   = CW'(1);
        end
      end
      LOCKED: begin
        // Any cycle the owner is not granted with lock held ends the lock.
        if (win_vld && (win_id == owner_q) && lck[owner_q]) begin
          if (cnt_q < CW'(LOCK_MAX)) cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = UNLOCKED;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      owner_q    <= REQ_CPU;
      cnt_q      <= '0;
      gid_q      <= REQ_CPU;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= REQ_CPU;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      rd_pend_q  <= win_vld && !mem_we;
      if (win_vld) begin
        gid_q      <= win_id;
        rd_owner_q <= win_id;
      end
    end
  end

  assign req0_rvalid = rd_pend_q && (rd_owner_q == REQ_CPU);
  assign req1_rvalid = rd_pend_q && (rd_owner_q == REQ_HOST);
  assign req0_rdata  = mem_rdata;
  assign req1_rdata  = mem_rdata;
  assign grant_id    = gid_q;
  assign lock_active = (state_q == LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random bench for mem_port_arbiter with a cycle-level reference model.
module tb_mem_port_arbiter;
  localparam int LOCK_MAX = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_we, req0_lock, req1_valid, req1_we, req1_lock;
  logic [3:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [3:0] req0_rdata, req1_rdata;
  logic       mem_en, mem_we, grant_id, lock_active;
  logic [3:0] mem_addr, mem_wdata, mem_rdata;

  logic [3:0] mem_arr [16] = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [3:0] ref_mem [16] = '{4'h0, 4'h1, 4'h2, 4'hA, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  int errors = 0;
  int checks = 0;

  // Reference model state: plain integers following the arbitration rules.
  int         m_last, m_gid, m_owner, m_cnt, m_rd_owner, last_w;
  bit         m_locked, m_rd_pend;
  logic [3:0] m_rd_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  mem_port_arbiter #(.AW(4), .DW(4), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_id(grant_id), .lock_active(lock_active)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_cnt = 0;
    m_last = 1; m_gid = 0; m_rd_pend = 0; m_rd_owner = 0;
  endtask

  // Compare all outputs against the model, then advance the model by one clock.
  task automatic check_and_advance();
    bit   v [2];
    bit   wev [2];
    bit   lk [2];
    logic [3:0] ad [2];
    logic [3:0] wd [2];
    int   w;
    v[0] = req0_valid; v[1] = req1_valid; wev[0] = req0_we; wev[1] = req1_we;
    lk[0] = req0_lock; lk[1] = req1_lock; ad[0] = req0_addr; ad[1] = req1_addr;
    wd[0] = req0_wdata; wd[1] = req1_wdata;

    if (m_locked && v[m_owner] && m_cnt < LOCK_MAX) w = m_owner;
    else if (v[0] && v[1]) w = 1 - m_last;
    else if (v[0])         w = 0;
    else if (v[1])         w = 1;
    else                   w = -1;
    last_w = w;

    chk("req0_ready", req0_ready, w == 0);
    chk("req1_ready", req1_ready, w == 1);
    chk("mem_en", mem_en, w >= 0);
    chk("mem_we", mem_we, (w >= 0) ? wev[w] : 1'b0);
    chk("mem_addr", mem_addr, (w >= 0) ? ad[w] : 4'h0);
    chk("mem_wdata", mem_wdata, (w >= 0) ? wd[w] : 4'h0);
    chk("req0_rvalid", req0_rvalid, m_rd_pend && m_rd_owner == 0);
    chk("req1_rvalid", req1_rvalid, m_rd_pend && m_rd_owner == 1);
    if (m_rd_pend && m_rd_owner == 0) chk("req0_rdata", req0_rdata, m_rd_data);
    if (m_rd_pend && m_rd_owner == 1) chk("req1_rdata", req1_rdata, m_rd_data);
    chk("grant_id", grant_id, m_gid);
    chk("lock_active", lock_active, m_locked);

    if (!m_locked) begin
      if (w >= 0 && lk[w]) begin m_locked = 1; m_owner = w; m_cnt = 1; end
    end else if (w == m_owner && lk[w]) begin
      m_cnt = (m_cnt + 1 > LOCK_MAX) ? LOCK_MAX : m_cnt + 1;
    end else begin
      m_locked = 0; m_cnt = 0;
    end

    m_rd_pend = 0;
    if (w >= 0) begin
      m_gid = w; m_last = w;
      if (wev[w]) ref_mem[ad[w]] = wd[w];
      else begin m_rd_pend = 1; m_rd_owner = w; m_rd_data = ref_mem[ad[w]]; end
    end
  endtask

  task automatic step(input logic v0, we0, lk0, input logic [3:0] a0, d0,
                      input logic v1, we1, lk1, input logic [3:0] a1, d1);
    @(negedge clk);
    req0_valid = v0; req0_we = we0; req0_lock = lk0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_lock = lk1; req1_addr = a1; req1_wdata = d1;
    #1;
    check_and_advance();
  endtask

  task automatic idle();
    step(0, 0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = 0; req1_wdata = 0;
    #1;
    chk("rst_rvalid0", req0_rvalid, 1'b0);
    chk("rst_rvalid1", req1_rvalid, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_lock_active", lock_active, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    apply_reset();

    // First read after reset: CPU reads addr 3.
    step(1, 0, 0, 4'h3, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    chk("rd3_ready0", req0_ready, 1'b1);
    idle();
    chk("rd3_rvalid0", req0_rvalid, 1'b1);
    chk("rd3_rdata0", req0_rdata, 4'hA);
    chk("rd3_rvalid1", req1_rvalid, 1'b0);

    // Plain round-robin from a fresh reset: 0,1,0,1,0,1.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 4'(i), 4'h0, 1, 0, 0, 4'(i + 8), 4'h0);
      chk("rr_alt", last_w, i % 2);
    end

    // CPU lock against a busy host: four CPU grants, then host.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 4'h1, 4'h0, 1, 0, 0, 4'h2, 4'h0);
      chk("lock_seq", last_w, (i < 4) ? 0 : 1);
    end
    idle();
    chk("lock_released", lock_active, 1'b0);

    // Host write, then CPU reads it back.
    step(0, 0, 0, 4'h0, 4'h0, 1, 1, 0, 4'h9, 4'h7);
    step(1, 0, 0, 4'h9, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    chk("wr_no_rvalid1", req1_rvalid, 1'b0);
    idle();
    chk("wr_rb_rvalid0", req0_rvalid, 1'b1);
    chk("wr_rb_rdata0", req0_rdata, 4'h7);

    // Owner drops valid while locked: host wins that same cycle.
    step(1, 0, 1, 4'h4, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    step(0, 0, 0, 4'h0, 4'h0, 1, 0, 0, 4'h5, 4'h0);
    chk("drop_ready1", req1_ready, 1'b1);
    idle();
    chk("drop_lock_active", lock_active, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(2) == 0,
           4'($urandom), 4'($urandom),
           $urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(2) == 0,
           4'($urandom), 4'($urandom));
    end

    // Read accepted, then reset lands before the return cycle.
    step(1, 0, 0, 4'h3, 4'h0, 0, 0, 0, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_rvalid0", req0_rvalid, 1'b0);
    chk("midrst_rvalid1", req1_rvalid, 1'b0);
    chk("midrst_grant_id", grant_id, 1'b0);
    chk("midrst_lock", lock_active, 1'b0);
    model_reset();
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 0, 0, 4'h1, 4'h0, 1, 0, 0, 4'h2, 4'h0);
    chk("post_rst_first", last_w, 0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
